// File: rtl/tiny_soc_sram_arbiter.sv
// Round-robin multi-port front-end for a single-port word SRAM with relocation, range checks and fixed read latency.
// Optional arbitration-loss counter enabled by TINY_SOC_SRAM_PERF_CNT_EN.
module tiny_soc_sram_arbiter #(
  parameter int unsigned          NumPorts    = 2,
  parameter int unsigned          AddrWidth   = 64,
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          NumWords    = 1 << 17,
  parameter int unsigned          ReadLatency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] strb_i,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic [NumPorts-1:0]             err_o,
  output logic [31:0]                     conflict_cnt_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffBits  = $clog2(NumBytes);
  localparam int unsigned PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrWidth-1:0] NumWordsA = AddrWidth'(NumWords);

  typedef struct packed {
    logic                 vld;
    logic [PtrW-1:0]      port;
    logic                 err;
    logic [DataWidth-1:0] data;
  } rsp_t;

  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic                 gnt_any;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW-1:0]      cand_idx;
  int unsigned          cand;

  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_we;
  logic [DataWidth-1:0] sel_wdata;
  logic [NumBytes-1:0]  sel_strb;
  logic [AddrWidth-1:0] offset;
  logic [AddrWidth-1:0] word_off;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic                 wr_en;

  logic [DataWidth-1:0] mem_q [NumWords];
  rsp_t                 rsp_d;
  rsp_t                 pipe_q [ReadLatency];
  rsp_t                 rsp_out;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    gnt_o    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumPorts) cand = cand - NumPorts;
      cand_idx = PtrW'(cand);
      if (!gnt_any && req_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (32'(gnt_idx) == NumPorts - 1) ptr_d = '0;
      else                              ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    sel_addr  = addr_i[gnt_idx*AddrWidth +: AddrWidth];
    sel_we    = we_i[gnt_idx];
    sel_wdata = wdata_i[gnt_idx*DataWidth +: DataWidth];
    sel_strb  = strb_i[gnt_idx*NumBytes +: NumBytes];
    offset    = sel_addr - BaseAddr;
    word_off  = offset >> OffBits;
    in_range  = (sel_addr >= BaseAddr) && (word_off < NumWordsA);
    idx       = word_off[IdxW-1:0];
    wr_en     = gnt_any && sel_we && in_range;
  end

  // SRAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (sel_strb[b]) mem_q[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rsp_d      = '0;
    rsp_d.vld  = gnt_any;
    rsp_d.port = gnt_idx;
    rsp_d.err  = gnt_any && !in_range;
    if (gnt_any && !sel_we && in_range) rsp_d.data = mem_q[idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int s = 0; s < ReadLatency; s++) pipe_q[s] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= rsp_d;
      for (int s = 1; s < ReadLatency; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  always_comb begin
    rsp_out  = pipe_q[ReadLatency-1];
    rvalid_o = '0;
    err_o    = '0;
    if (rsp_out.vld) begin
      rvalid_o[rsp_out.port] = 1'b1;
      err_o[rsp_out.port]    = rsp_out.err;
    end
    rdata_o = rsp_out.data;
  end

`ifdef TINY_SOC_SRAM_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((|(req_i & ~gnt_o)) && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tiny_soc_sram_arbiter.sv
// Randomized scoreboard bench: requesters hold until granted, a reference model predicts grants and responses.
module tb_tiny_soc_sram_arbiter;
  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NW = 64;
  localparam int RL = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP*8-1:0]   strb_i;
  logic [DW-1:0]     rdata_o;
  logic [31:0]       conflict_cnt_o;

  tiny_soc_sram_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW),
    .ReadLatency(RL), .BaseAddr(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .strb_i(strb_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          err;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mmem [NW];
  bit          pend [NP];
  logic [63:0] p_addr [NP];
  bit          p_we [NP];
  logic [63:0] p_wdata [NP];
  logic [7:0]  p_strb [NP];
  int          rr = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  longint      conf_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < NP; p++) begin
      req_i[p]            = pend[p];
      we_i[p]             = p_we[p];
      addr_i[p*AW +: AW]  = p_addr[p];
      wdata_i[p*DW +: DW] = p_wdata[p];
      strb_i[p*8 +: 8]    = p_strb[p];
    end
  endtask

  task automatic new_req(input int p);
    int r;
    r = $urandom_range(0, 9);
    pend[p] = 1'b1;
    p_we[p] = 1'($urandom_range(0, 1));
    if (r < 5)       p_addr[p] = BASE + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
    else if (r < 7)  p_addr[p] = BASE + 64'($urandom_range(0, NW - 1)) * 8;
    else if (r == 7) p_addr[p] = BASE - 64'($urandom_range(1, 4)) * 8;
    else if (r == 8) p_addr[p] = BASE + 64'(NW) * 8 + 64'($urandom_range(0, 64));
    else             p_addr[p] = {$urandom, $urandom};
    p_wdata[p] = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       p_strb[p] = 8'hFF;
      1:       p_strb[p] = 8'h00;
      2:       p_strb[p] = 8'h0F;
      default: p_strb[p] = 8'($urandom);
    endcase
  endtask

  // One cycle: optionally issue new requests, predict the grant, queue the expected response.
  task automatic step(input bit rand_mode);
    int          w;
    int          q;
    logic [63:0] a, wi;
    bit          inr;
    exp_t        e;
    @(negedge clk);
    if (rand_mode)
      for (int p = 0; p < NP; p++)
        if (!pend[p] && $urandom_range(0, 9) < 6) new_req(p);
    apply();
    #1;
    w = -1;
    for (int i = 0; i < NP; i++) begin
      q = (rr + i) % NP;
      if (pend[q] && w < 0) w = q;
    end
    check("gnt", 64'(gnt_o), (w >= 0) ? (64'd1 << w) : 64'd0);
    for (int p = 0; p < NP; p++)
      if (pend[p] && p != w) begin
        conf_model++;
        break;
      end
    if (w >= 0) begin
      a   = p_addr[w];
      wi  = (a - BASE) >> 3;
      inr = (a >= BASE) && (wi < 64'(NW));
      e.port = w;
      e.err  = !inr;
      e.data = '0;
      e.due  = cyc + RL;
      if (inr && p_we[w]) begin
        for (int b = 0; b < 8; b++)
          if (p_strb[w][b]) mmem[int'(wi)][b*8 +: 8] = p_wdata[w][b*8 +: 8];
      end else if (inr) begin
        e.data = mmem[int'(wi)];
      end
      sbq.push_back(e);
      pend[w] = 1'b0;
      rr = (w + 1) % NP;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    apply();
    sbq.delete();
    rr = 0;
    conf_model = 0;
    @(negedge clk);
    #1;
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_cnt", 64'(conflict_cnt_o), 64'd0);
    rst = 1'b0;
  endtask

  // Monitor: every response pulse is popped and compared, including its arrival cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rvalid_o != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rvalid %b expected none (cycle %0d)", rvalid_o, cyc);
        end else begin
          e = sbq.pop_front();
          check("rsp_rvalid", 64'(rvalid_o), 64'd1 << e.port);
          check("rsp_err", 64'(err_o), e.err ? (64'd1 << e.port) : 64'd0);
          check("rsp_rdata", rdata_o, e.data);
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid: got none expected port %0d due cycle %0d (cycle %0d)", e.port, e.due, cyc);
      end
    end
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; p_strb[p] = '0;
    end
    apply();
    repeat (2) @(negedge clk);
    #1;
    check("reset_gnt", 64'(gnt_o), 64'd0);
    check("reset_rvalid", 64'(rvalid_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    check("reset_rdata", rdata_o, 64'd0);
    check("reset_cnt", 64'(conflict_cnt_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NW; i++) begin
      pend[0] = 1'b1; p_we[0] = 1'b1; p_strb[0] = 8'hFF;
      p_addr[0] = BASE + 64'(i) * 8;
      p_wdata[0] = {$urandom, $urandom};
      step(1'b0);
    end

    for (int i = 0; i < 400; i++) step(1'b1);

    for (int i = 0; i < 50 && sbq.size() == 0; i++) step(1'b1);
    do_reset();

    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b1; p_we[p] = 1'b0; p_addr[p] = BASE; p_strb[p] = 8'hFF;
    end
    step(1'b0);

    for (int i = 0; i < 400; i++) step(1'b1);
    repeat (NP * 2 + RL + 2) step(1'b0);
    check("drain_empty", 64'(sbq.size()), 64'd0);
`ifdef TINY_SOC_SRAM_PERF_CNT_EN
    check("conflict_cnt", 64'(conflict_cnt_o), 64'(conf_model));
`else
    check("conflict_cnt", 64'(conflict_cnt_o), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
